// File: rtl/eeg_input_writer.sv
// -----------------------------------------------------------------------------
// eeg_input_writer
//   Captures one EEG epoch of NUM_SAMPLES ADC samples and writes each converted
//   sample into the intermediate-result memory starting at BASE_ADDR.
//   Each sample is centred (offset-binary to two's complement), arithmetically
//   shifted right by ADC_SHIFT and reduced to a 9-bit signed word.
//
//   Optional feature macro: EEG_INPUT_SAT_EN
//     defined   : shifted sample saturates to [-256, 255]
//     undefined : shifted sample wraps to its low 9 bits
// -----------------------------------------------------------------------------
module eeg_input_writer #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NUM_SAMPLES = 3840,
    parameter int unsigned ADC_SHIFT   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    output logic        adc_ready,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_addr,
    output logic [8:0]  mem_wr_data,
    input  logic        mem_wr_grant,
    output logic        busy,
    output logic        done,
    output logic [11:0] sample_cnt
);

    localparam logic [15:0] BASE_C = 16'(BASE_ADDR);
    localparam logic [11:0] NUM_C  = 12'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SAMPLE = 2'd1,
        WRITE       = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        adc_ready_q, adc_ready_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;

    logic signed [15:0] centred;
    logic [8:0]         conv_sample;
    logic [11:0]        cnt_inc;

    // Centre the offset-binary sample, shift it down and reduce it to 9 bits
    always_comb begin
        centred = {~adc_data[15], adc_data[14:0]};
`ifdef EEG_INPUT_SAT_EN
        begin
            logic signed [15:0] shifted;
            shifted = centred >>> ADC_SHIFT;
            if (shifted > 16'sd255) begin
                conv_sample = 9'h0FF;
            end else if (shifted < -16'sd256) begin
                conv_sample = 9'h100;
            end else begin
                conv_sample = shifted[8:0];
            end
        end
`else
        conv_sample = 9'(centred >>> ADC_SHIFT);
`endif
    end

    // Next-state and next-output logic; every output is derived from the next state
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cnt_inc      = sample_cnt_q + 12'd1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sample_cnt_d = '0;
                    state_d      = WAIT_SAMPLE;
                end
            end
            WAIT_SAMPLE: begin
                if (adc_valid && adc_ready_q) begin
                    wr_data_d = conv_sample;
                    wr_addr_d = BASE_C + {4'b0000, sample_cnt_q};
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (mem_wr_grant && mem_wr_en_q) begin
                    sample_cnt_d = cnt_inc;
                    state_d      = (cnt_inc == NUM_C) ? DONE : WAIT_SAMPLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        adc_ready_d = (state_d == WAIT_SAMPLE);
        mem_wr_en_d = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            adc_ready_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sample_cnt_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            adc_ready_q  <= adc_ready_d;
            mem_wr_en_q  <= mem_wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sample_cnt_q <= sample_cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign adc_ready   = adc_ready_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_eeg_input_writer.sv
// -----------------------------------------------------------------------------
// tb_eeg_input_writer
//   Self-checking bench for eeg_input_writer. Expected samples come from an
//   integer reference of the conversion rule; writes are scored against a
//   queue of accepted samples. Honours EEG_INPUT_SAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_eeg_input_writer;

    localparam int N     = 3840;
    localparam int SHIFT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        mem_wr_grant = 1'b0;
    logic        adc_ready;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [8:0]  mem_wr_data;
    logic        busy;
    logic        done;
    logic [11:0] sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    eeg_input_writer #(
        .BASE_ADDR  (0),
        .NUM_SAMPLES(N),
        .ADC_SHIFT  (SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .adc_ready   (adc_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_grant(mem_wr_grant),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt)
    );

    // Reference conversion: subtract the mid-scale offset, floor-divide by 2^SHIFT
    function automatic logic [8:0] ref_conv(input logic [15:0] s);
        int c;
        int sh;
        int div;
        div = 1 << SHIFT;
        c   = int'(s) - 32768;
        if (c >= 0) sh = c / div;
        else        sh = -((-c + div - 1) / div);
`ifdef EEG_INPUT_SAT_EN
        if (sh > 255)  sh = 255;
        if (sh < -256) sh = -256;
`endif
        return 9'(sh);
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        adc_valid = 1'b1;
        adc_data = 16'h1234;
        mem_wr_grant = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({adc_ready, mem_wr_en, busy, done, sample_cnt, mem_wr_addr, mem_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b en=%b busy=%b done=%b cnt=%0d addr=%0h data=%0h expected all 0",
                     adc_ready, mem_wr_en, busy, done, sample_cnt, mem_wr_addr, mem_wr_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({adc_ready, mem_wr_en, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_without_start: got rdy=%b en=%b busy=%b expected 000", adc_ready, mem_wr_en, busy);
        end
        adc_valid = 1'b0;
        mem_wr_grant = 1'b0;
    endtask

    task automatic test_conversion();
        logic [15:0] vals[$];
        logic [8:0]  exp_d;
        vals = '{16'h8000, 16'h8100, 16'h7F00, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 20; i++) vals.push_back(16'($urandom));
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || sample_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL start_state: got busy=%b cnt=%0d expected busy=1 cnt=0", busy, sample_cnt);
        end
        exp_cnt = 0;
        mem_wr_grant = 1'b1;
        foreach (vals[k]) begin
            n_checks++;
            if (adc_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL conv_ready[%0d]: got %b expected 1", k, adc_ready);
            end
            adc_valid = 1'b1;
            adc_data  = vals[k];
            exp_d     = ref_conv(vals[k]);
            @(negedge clk);
            adc_valid = 1'b0;
            n_checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'(exp_cnt) || mem_wr_data !== exp_d) begin
                n_fail++;
                $display("FAIL conv_write[%0h]: got en=%b addr=%0d data=%0h expected en=1 addr=%0d data=%0h",
                         vals[k], mem_wr_en, mem_wr_addr, mem_wr_data, exp_cnt, exp_d);
            end
            @(negedge clk);
            exp_cnt++;
            n_checks++;
            if (sample_cnt !== 12'(exp_cnt) || mem_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL conv_count: got cnt=%0d en=%b expected cnt=%0d en=0", sample_cnt, mem_wr_en, exp_cnt);
            end
        end
        mem_wr_grant = 1'b0;
    endtask

    task automatic test_stall();
        logic [15:0] d;
        d = 16'($urandom);
        adc_valid = 1'b1;
        adc_data  = d;
        @(negedge clk);
        adc_data = ~d;
        start    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'(exp_cnt) || mem_wr_data !== ref_conv(d) || adc_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got en=%b addr=%0d data=%0h rdy=%b expected en=1 addr=%0d data=%0h rdy=0",
                         c, mem_wr_en, mem_wr_addr, mem_wr_data, adc_ready, exp_cnt, ref_conv(d));
            end
            @(negedge clk);
            start = 1'b0;
        end
        adc_valid    = 1'b0;
        mem_wr_grant = 1'b1;
        @(negedge clk);
        mem_wr_grant = 1'b0;
        exp_cnt++;
        n_checks++;
        if (sample_cnt !== 12'(exp_cnt) || mem_wr_en !== 1'b0 || adc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got cnt=%0d en=%b rdy=%b expected cnt=%0d en=0 rdy=1",
                     sample_cnt, mem_wr_en, adc_ready, exp_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_buffer: got en=%b expected 0", mem_wr_en);
        end
    endtask

    task automatic test_reset_mid_epoch();
        int writes;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        mem_wr_grant = 1'b1;
        for (int i = 0; i < 100; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            @(negedge clk);
            adc_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (sample_cnt !== 12'd100) begin
            n_fail++;
            $display("FAIL mid_count: got %0d expected 100", sample_cnt);
        end
        mem_wr_grant = 1'b0;
        adc_valid    = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({adc_ready, mem_wr_en, busy, done, sample_cnt, mem_wr_addr, mem_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b en=%b busy=%b cnt=%0d addr=%0h data=%0h expected all 0",
                     adc_ready, mem_wr_en, busy, sample_cnt, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        mem_wr_grant = 1'b1;
        writes       = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_wr_en || busy) writes++;
        end
        n_checks++;
        if (writes != 0) begin
            n_fail++;
            $display("FAIL mid_abandon: got %0d active cycles expected 0", writes);
        end
        adc_valid = 1'b0;
        pulse_start();
        adc_valid = 1'b1;
        adc_data  = 16'h8100;
        @(negedge clk);
        adc_valid = 1'b0;
        n_checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'd0 || mem_wr_data !== ref_conv(16'h8100)) begin
            n_fail++;
            $display("FAIL mid_restart: got en=%b addr=%0d data=%0h expected en=1 addr=0 data=%0h",
                     mem_wr_en, mem_wr_addr, mem_wr_data, ref_conv(16'h8100));
        end
        mem_wr_grant = 1'b0;
    endtask

    task automatic test_full_epoch();
        logic [8:0]  q[$];
        logic [8:0]  exp_d;
        logic [15:0] d;
        logic [15:0] addr_o, hold_addr;
        logic [8:0]  data_o, hold_data;
        logic        v, g, en_o, rdy_o, done_o, busy_o, holding;
        int cyc, written, done_seen, last_grant, acc_cyc, done_cyc;
        cyc = 0; written = 0; done_seen = 0;
        last_grant = -10; acc_cyc = -10; done_cyc = -10; holding = 1'b0;
        hold_addr = '0; hold_data = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        while (cyc < 40000) begin
            en_o = mem_wr_en; rdy_o = adc_ready; done_o = done; busy_o = busy;
            addr_o = mem_wr_addr; data_o = mem_wr_data;
            if (cyc == acc_cyc + 1) begin
                n_checks++;
                if (en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL epoch_latency@%0d: got en=%b expected 1", cyc, en_o);
                end
            end
            if (holding) begin
                n_checks++;
                if (en_o !== 1'b1 || addr_o !== hold_addr || data_o !== hold_data) begin
                    n_fail++;
                    $display("FAIL epoch_hold@%0d: got en=%b addr=%0d data=%0h expected en=1 addr=%0d data=%0h",
                             cyc, en_o, addr_o, data_o, hold_addr, hold_data);
                end
            end
            if (rdy_o && en_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL epoch_ready_excl@%0d: got rdy=1 en=1 expected not both", cyc);
            end
            if (done_o) begin
                done_seen++;
                done_cyc = cyc;
                n_checks++;
                if (cyc != last_grant + 1) begin
                    n_fail++;
                    $display("FAIL epoch_done_time: got cycle %0d expected %0d", cyc, last_grant + 1);
                end
            end
            if (cyc == done_cyc + 1) begin
                n_checks++;
                if (busy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL epoch_busy_drop: got %b expected 0", busy_o);
                end
                break;
            end
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            adc_valid = v; adc_data = d; mem_wr_grant = g;
            if (rdy_o && v) begin
                q.push_back(ref_conv(d));
                acc_cyc = cyc;
            end
            holding = en_o && !g;
            hold_addr = addr_o; hold_data = data_o;
            if (en_o && g) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL epoch_spurious_write: got write addr=%0d expected none", addr_o);
                end else begin
                    exp_d = q.pop_front();
                    if (addr_o !== 16'(written) || data_o !== exp_d) begin
                        n_fail++;
                        $display("FAIL epoch_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 addr_o, data_o, written, exp_d);
                    end
                end
                written++;
                if (written == N) last_grant = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        adc_valid = 1'b0;
        mem_wr_grant = 1'b0;
        n_checks++;
        if (written != N || done_seen != 1 || q.size() != 0) begin
            n_fail++;
            $display("FAIL epoch_totals: got writes=%0d dones=%0d pending=%0d expected writes=%0d dones=1 pending=0",
                     written, done_seen, q.size(), N);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (sample_cnt !== 12'(N) || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL epoch_final: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=0 done=0",
                     sample_cnt, busy, done, N);
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_stall();
        test_reset_mid_epoch();
        test_full_epoch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
